ifetch_unit: RTL

- Fetch-side initiator that drives the byte address into the instruction memory and consumes the 32-bit little-endian word it returns combinationally.
- Holds the PC and computes next-PC, either sequential +4 or a redirect from execute.
- Presents fetched instructions to decode through a one-entry valid/ready output register.
- Detects misaligned and out-of-range PCs and parks in a fault state.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 53 +++++
 rtl/ifetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and default sizes for the CPU front end.
package cpu_pkg;

    // Default datapath and memory geometry.
    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int IMEM_BYTES = 128;
    localparam int PC_STEP    = 4;

    // Fetch unit is either streaming or parked on a bad PC until reset.
    typedef enum logic {
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_t;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection and PC legality check for the fetch unit.
// A redirect always wins over sequential fetch; a sequential fetch only
// proceeds when the output slot is free, and only from a legal PC.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int pc_len = PC_W,
    parameter int d      = IMEM_BYTES
) (
    input  logic [pc_len-1:0] i_pc,
    input  logic              i_redirect_valid,
    input  logic [pc_len-1:0] i_redirect_pc,
    input  logic              i_free,
    output logic [pc_len-1:0] o_next_pc,
    output logic              o_capture,
    output logic              o_fault_detect
);

    // Highest byte address from which a full word can still be fetched.
    localparam logic [pc_len-1:0] LAST_PC = pc_len'(d - PC_STEP);

    logic w_pc_bad;
    logic w_redirect_bad;

    // A PC is bad if it is not word aligned or the word would run past memory.
    assign w_pc_bad       = (i_pc[1:0] != 2'b00) || (i_pc > LAST_PC);
    assign w_redirect_bad = (i_redirect_pc[1:0] != 2'b00) || (i_redirect_pc > LAST_PC);

    // Priority: redirect (good or bad), then sequential capture, else hold.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        o_next_pc      = i_pc;
        o_capture      = 1'b0;
        o_fault_detect = 1'b0;
        if (i_redirect_valid) begin
            if (w_redirect_bad) begin
                o_fault_detect = 1'b1;
            end else begin
                o_next_pc = i_redirect_pc;
            end
        end else if (i_free) begin
            // The range check is deferred while decode stalls the slot.
            if (w_pc_bad) begin
                o_fault_detect = 1'b1;
            end else begin
                o_capture = 1'b1;
                // Wraps modulo 2^pc_len; the range check fires before use.
                o_next_pc = i_pc + pc_len'(PC_STEP);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives the PC to a combinational instruction
// memory, captures the returned word into a one-entry valid/ready output
// register for decode, follows redirects from execute, and parks in a
// sticky fault state on a misaligned or out-of-range PC.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int                w        = INSTR_W,
    parameter int                pc_len   = PC_W,
    parameter int                d        = IMEM_BYTES,
    parameter logic [pc_len-1:0] reset_pc = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [pc_len-1:0] pcaddress,
    input  logic [w-1:0]      instruction,
    input  logic              redirect_valid,
    input  logic [pc_len-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [w-1:0]      out_instr,
    output logic [pc_len-1:0] out_pc,
    output logic              fault,
    output logic [pc_len-1:0] fault_pc
);

    // Architectural state.
    fetch_state_t      r_state;
    logic [pc_len-1:0] r_pc;
    logic              r_out_valid;
    logic [w-1:0]      r_out_instr;
    logic [pc_len-1:0] r_out_pc;
    logic              r_fault;
    logic [pc_len-1:0] r_fault_pc;

    // Next-state values.
    fetch_state_t      w_state_nxt;
    logic [pc_len-1:0] w_pc_nxt;
    logic              w_out_valid_nxt;
    logic [w-1:0]      w_out_instr_nxt;
    logic [pc_len-1:0] w_out_pc_nxt;
    logic              w_fault_nxt;
    logic [pc_len-1:0] w_fault_pc_nxt;

    // Outputs of the next-PC selector.
    logic              w_free;
    logic [pc_len-1:0] w_sel_next_pc;
    logic              w_sel_capture;
    logic              w_sel_fault;

    // The output slot can take a new word when empty or being drained.
    assign w_free = !r_out_valid || out_ready;

    pc_next_sel #(
        .pc_len (pc_len),
        .d      (d)
    ) u_pc_next_sel (
        .i_pc             (r_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_free           (w_free),
        .o_next_pc        (w_sel_next_pc),
        .o_capture        (w_sel_capture),
        .o_fault_detect   (w_sel_fault)
    );

    // Next-state logic: RUN follows the selector, FAULT freezes everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_instr_nxt = r_out_instr;
        w_out_pc_nxt    = r_out_pc;
        w_fault_nxt     = r_fault;
        w_fault_pc_nxt  = r_fault_pc;
        case (r_state)
            FETCH_RUN: begin
                if (w_sel_fault) begin
                    // Blame the redirect target if one was presented,
                    // otherwise the PC we were about to fetch from.
                    w_state_nxt     = FETCH_FAULT;
                    w_fault_nxt     = 1'b1;
                    w_fault_pc_nxt  = redirect_valid ? redirect_pc : r_pc;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_pc_nxt = w_sel_next_pc;
                    if (redirect_valid) begin
                        // Flush, even if decode is still holding the slot.
                        w_out_valid_nxt = 1'b0;
                    end else if (w_sel_capture) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_instr_nxt = instruction;
                        w_out_pc_nxt    = r_pc;
                    end
                end
            end
            FETCH_FAULT: begin
                // Parked: redirects are ignored and nothing is captured.
                w_out_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = FETCH_FAULT;
            end
        endcase
    end

    // State register with synchronous reset that overrides every other event.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together.
        if (rst) begin
            r_state     <= FETCH_RUN;
            r_pc        <= reset_pc;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
            r_fault     <= 1'b0;
            r_fault_pc  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_fault     <= w_fault_nxt;
            r_fault_pc  <= w_fault_pc_nxt;
        end
    end

    assign pcaddress = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;

endmodule
